// File: rtl/nmi_arb2_if.sv
// -----------------------------------------------------------------------------
// nmi_if : native memory interface (NMI) bundle.
//
// A single request/response channel. The master drives a request (valid, addr,
// wdata, wstrb) and holds it until the slave answers with ready, which is also
// the cycle in which rdata is valid. Reads and writes share the same handshake.
//
//   valid  master -> slave  request present
//   addr   master -> slave  byte address [31:0]
//   wdata  master -> slave  write data [31:0]
//   wstrb  master -> slave  byte write strobes [3:0] (all zero for a read)
//   ready  slave -> master  request accepted / completed this cycle
//   rdata  slave -> master  read data, valid while ready is high
// -----------------------------------------------------------------------------
interface nmi_if;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output valid, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, addr, wdata, wstrb,
      output ready, rdata
   );
endinterface

// File: rtl/nmi_arb2.sv
// -----------------------------------------------------------------------------
// nmi_arb2 : two-master NMI arbiter with bus-timeout protection.
//
// Merges master 0 (CPU) and master 1 (DMA/debug) onto one downstream NMI slave
// port. A request seen in IDLE is granted on the next cycle; on a tie the
// master that was not served last wins. While granted, the request is passed
// straight through to the slave and the slave's response straight back to the
// granted master, so a response adds no latency. If the slave never answers,
// the transaction is terminated after TIMEOUT_CYC granted cycles with ERR_DATA,
// an error pulse and a record of the offending address.
//
// Parameters
//   TIMEOUT_CYC  granted cycles without s.ready before forced termination
//                (0 disables the timeout)
//   ERR_DATA     rdata returned to the master on a timed-out transaction
//
// Ports
//   clk_i       in   system clock, all state on the rising edge
//   rst_n_i     in   asynchronous active-low reset
//   m0          NMI slave side facing master 0 (CPU)
//   m1          NMI slave side facing master 1 (DMA/debug)
//   s           NMI master side facing the downstream peripheral wrapper
//   err_o       out  one-cycle pulse in the cycle a timeout terminates a request
//   err_addr_o  out  address of the most recent timed-out request
// -----------------------------------------------------------------------------
module nmi_arb2 #(
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   nmi_if.slave        m0,
   nmi_if.slave        m1,
   nmi_if.master       s,
   output logic        err_o,
   output logic [31:0] err_addr_o
);

   // Counter wide enough to hold TIMEOUT_CYC; kept at one bit when disabled.
   localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam bit          TO_EN = (TIMEOUT_CYC != 0);
   // The timeout fires in the GRANT cycle where the count of earlier stalled
   // GRANT cycles reaches TIMEOUT_CYC-1, i.e. in the TIMEOUT_CYC-th GRANT cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t            r_state;
   logic              r_gnt;       // granted master: 0 = m0, 1 = m1
   logic              r_last;      // master served by the last finished request
   logic [CNT_W-1:0]  r_cnt;       // stalled GRANT cycles so far
   logic [31:0]       r_err_addr;

   logic              w_busy;
   logic              w_gnt_valid;
   logic [31:0]       w_gnt_addr;
   logic [31:0]       w_gnt_wdata;
   logic [3:0]        w_gnt_wstrb;
   logic              w_done;
   logic              w_timeout;
   logic              w_resp;
   logic [31:0]       w_resp_data;

   // ---------------------------------------------------------------------------
   // Granted-master request mux and response qualification
   // ---------------------------------------------------------------------------
   assign w_busy      = (r_state == ST_GRANT);
   assign w_gnt_valid = r_gnt ? m1.valid : m0.valid;
   assign w_gnt_addr  = r_gnt ? m1.addr  : m0.addr;
   assign w_gnt_wdata = r_gnt ? m1.wdata : m0.wdata;
   assign w_gnt_wstrb = r_gnt ? m1.wstrb : m0.wstrb;

   // A master that withdraws its request mid-grant gets neither a normal nor a
   // timeout response, hence both terms are qualified by the granted valid.
   assign w_done    = w_busy & w_gnt_valid & s.ready;
   // A slave answering in the very cycle the timeout would fire wins: the
   // timeout term requires s.ready low.
   assign w_timeout = TO_EN && w_busy && w_gnt_valid && !s.ready && (r_cnt == CNT_LAST);

   assign w_resp      = w_done | w_timeout;
   assign w_resp_data = w_timeout ? ERR_DATA : s.rdata;

   // ---------------------------------------------------------------------------
   // Downstream request: pass-through while granted, withdrawn on timeout so the
   // slave never sees a request whose response was already faked.
   // ---------------------------------------------------------------------------
   assign s.valid = w_busy & w_gnt_valid & ~w_timeout;
   assign s.addr  = w_busy ? w_gnt_addr  : '0;
   assign s.wdata = w_busy ? w_gnt_wdata : '0;
   assign s.wstrb = w_busy ? w_gnt_wstrb : '0;

   // ---------------------------------------------------------------------------
   // Upstream responses: only the granted master ever sees ready/rdata.
   // ---------------------------------------------------------------------------
   assign m0.ready = w_resp & ~r_gnt;
   assign m1.ready = w_resp &  r_gnt;
   assign m0.rdata = (w_busy & ~r_gnt) ? w_resp_data : '0;
   assign m1.rdata = (w_busy &  r_gnt) ? w_resp_data : '0;

   assign err_o      = w_timeout;
   assign err_addr_o = r_err_addr;

   // ---------------------------------------------------------------------------
   // Arbitration / grant FSM
   // ---------------------------------------------------------------------------
   // NOTE: state is updated only with non-blocking assignments so every register
   // samples the pre-edge values of the others, whatever the statement order.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_IDLE;
         r_gnt      <= 1'b0;
         r_last     <= 1'b1;     // m0 wins the first tie
         r_cnt      <= '0;
         r_err_addr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (m0.valid | m1.valid) begin
                  r_state <= ST_GRANT;
                  // Round-robin on a tie, otherwise the sole requester.
                  r_gnt   <= (m0.valid & m1.valid) ? ~r_last : m1.valid;
               end
            end

            ST_GRANT: begin
               if (!w_gnt_valid) begin
                  // Protocol violation: abandon silently, fairness untouched.
                  r_state <= ST_IDLE;
               end else if (w_done) begin
                  r_state <= ST_IDLE;
                  r_last  <= r_gnt;
               end else if (w_timeout) begin
                  r_state    <= ST_IDLE;
                  r_last     <= r_gnt;
                  r_err_addr <= w_gnt_addr;
               end else if (TO_EN) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nmi_arb2.sv
// -----------------------------------------------------------------------------
// tb_nmi_arb2 : self-checking bench for nmi_arb2.
//
// Two arbiters run side by side: dut_a with an 8-cycle timeout and dut_b with
// the timeout disabled. The bench plays both masters and the downstream slave.
// Expectations come from a transaction-level model: the winner of a tie is the
// master not served last, a request whose slave latency L (in GRANT cycles) is
// at most TIMEOUT_CYC completes in GRANT cycle L with the slave data, and a
// longer one ends in GRANT cycle TIMEOUT_CYC with the error word and flag.
// -----------------------------------------------------------------------------
module tb_nmi_arb2;

   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
   localparam int          TO_A     = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Bench-side drive for [dut][master] and for each dut's slave.
   logic        mv  [2][2];
   logic [31:0] ma  [2][2];
   logic [31:0] mwd [2][2];
   logic [3:0]  mws [2][2];
   logic        sr  [2];
   logic [31:0] srd [2];

   // Observed DUT outputs.
   logic        o_mr  [2][2];
   logic [31:0] o_mrd [2][2];
   logic        o_sv  [2];
   logic [31:0] o_sa  [2];
   logic [31:0] o_swd [2];
   logic [3:0]  o_sws [2];
   logic        o_err [2];
   logic [31:0] o_eaddr [2];

   int checks = 0;
   int errors = 0;

   nmi_if m0_a (), m1_a (), s_a ();
   nmi_if m0_b (), m1_b (), s_b ();

   nmi_arb2 #(.TIMEOUT_CYC(TO_A), .ERR_DATA(ERR_WORD)) dut_a (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .m0         (m0_a),
      .m1         (m1_a),
      .s          (s_a),
      .err_o      (o_err[0]),
      .err_addr_o (o_eaddr[0])
   );

   nmi_arb2 #(.TIMEOUT_CYC(0), .ERR_DATA(ERR_WORD)) dut_b (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .m0         (m0_b),
      .m1         (m1_b),
      .s          (s_b),
      .err_o      (o_err[1]),
      .err_addr_o (o_eaddr[1])
   );

   assign m0_a.valid = mv[0][0];  assign m1_a.valid = mv[0][1];
   assign m0_a.addr  = ma[0][0];  assign m1_a.addr  = ma[0][1];
   assign m0_a.wdata = mwd[0][0]; assign m1_a.wdata = mwd[0][1];
   assign m0_a.wstrb = mws[0][0]; assign m1_a.wstrb = mws[0][1];
   assign s_a.ready  = sr[0];     assign s_a.rdata  = srd[0];
   assign m0_b.valid = mv[1][0];  assign m1_b.valid = mv[1][1];
   assign m0_b.addr  = ma[1][0];  assign m1_b.addr  = ma[1][1];
   assign m0_b.wdata = mwd[1][0]; assign m1_b.wdata = mwd[1][1];
   assign m0_b.wstrb = mws[1][0]; assign m1_b.wstrb = mws[1][1];
   assign s_b.ready  = sr[1];     assign s_b.rdata  = srd[1];

   assign o_mr[0][0]  = m0_a.ready; assign o_mr[0][1]  = m1_a.ready;
   assign o_mrd[0][0] = m0_a.rdata; assign o_mrd[0][1] = m1_a.rdata;
   assign o_mr[1][0]  = m0_b.ready; assign o_mr[1][1]  = m1_b.ready;
   assign o_mrd[1][0] = m0_b.rdata; assign o_mrd[1][1] = m1_b.rdata;
   assign o_sv[0]  = s_a.valid; assign o_sa[0]  = s_a.addr;
   assign o_swd[0] = s_a.wdata; assign o_sws[0] = s_a.wstrb;
   assign o_sv[1]  = s_b.valid; assign o_sa[1]  = s_b.addr;
   assign o_swd[1] = s_b.wdata; assign o_sws[1] = s_b.wstrb;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // All outputs of one dut at their idle/reset values.
   task automatic check_quiet(input int d, input string pfx);
      check({pfx, "_m0_ready"}, 32'(o_mr[d][0]), 32'd0);
      check({pfx, "_m1_ready"}, 32'(o_mr[d][1]), 32'd0);
      check({pfx, "_m0_rdata"}, o_mrd[d][0], 32'd0);
      check({pfx, "_m1_rdata"}, o_mrd[d][1], 32'd0);
      check({pfx, "_s_valid"},  32'(o_sv[d]), 32'd0);
      check({pfx, "_s_addr"},   o_sa[d], 32'd0);
      check({pfx, "_s_wdata"},  o_swd[d], 32'd0);
      check({pfx, "_s_wstrb"},  32'(o_sws[d]), 32'd0);
      check({pfx, "_err"},      32'(o_err[d]), 32'd0);
      check({pfx, "_err_addr"}, o_eaddr[d], 32'd0);
   endtask

   // Plays the slave of dut d for one transaction. Entered and left at 1 time
   // unit after a rising edge (the exit cycle is the one after the response).
   // lat = GRANT cycle in which the slave raises ready (0 = never).
   task automatic run_txn(
      input  int          d,
      input  int          lat,
      input  logic [31:0] data,
      input  bit          drop,
      input  int          budget,
      output bit          done,
      output int          who,
      output int          idle_n,
      output int          k,
      output logic [31:0] rdata,
      output logic        sv_at_resp,
      output logic        err_at_resp,
      output logic        err_any,
      output logic [31:0] g_addr,
      output logic [31:0] g_wdata,
      output logic [3:0]  g_wstrb
   );
      bit started = 0;
      done = 0; who = -1; idle_n = 0; k = 0; rdata = '0;
      sv_at_resp = 1'bx; err_at_resp = 1'bx; err_any = 1'b0;
      g_addr = '0; g_wdata = '0; g_wstrb = '0;
      for (int c = 0; c < budget && !done; c++) begin
         sr[d]  = 1'b0;
         srd[d] = data;
         #1;
         if (!started) begin
            if (o_sv[d]) begin
               started = 1;
               k       = 1;
               g_addr  = o_sa[d];
               g_wdata = o_swd[d];
               g_wstrb = o_sws[d];
            end else begin
               idle_n++;
            end
         end
         if (started) begin
            sr[d] = (k == lat);
            #1;
            err_any = err_any | o_err[d];
            if (o_mr[d][0] | o_mr[d][1]) begin
               who         = o_mr[d][1] ? 1 : 0;
               rdata       = o_mrd[d][who];
               sv_at_resp  = o_sv[d];
               err_at_resp = o_err[d];
               done        = 1;
            end else begin
               k++;
            end
         end
         @(posedge clk);
         #1;
      end
      sr[d] = 1'b0;
      if (drop) begin
         mv[d][0] = 1'b0;
         mv[d][1] = 1'b0;
      end
   endtask

   initial begin : stim
      bit          done;
      int          who, idle_n, k, last_m, exp_who, mode, lat;
      logic [31:0] rd, data, ga, gwd, exp_eaddr;
      logic [3:0]  gws;
      logic        sv_r, er_r, er_any;
      bit          exp_to;

      for (int d = 0; d < 2; d++) begin
         sr[d] = 1'b0; srd[d] = '0;
         for (int m = 0; m < 2; m++) begin
            mv[d][m] = 1'b0; ma[d][m] = '0; mwd[d][m] = '0; mws[d][m] = '0;
         end
      end
      last_m    = 1;
      exp_eaddr = '0;

      // ---- reset values, with both dut_a masters already requesting ----
      rst_n    = 1'b0;
      mv[0][0] = 1'b1; ma[0][0] = 32'h0000_A000; mwd[0][0] = 32'h1111_0000; mws[0][0] = 4'h3;
      mv[0][1] = 1'b1; ma[0][1] = 32'h0000_B000; mwd[0][1] = 32'h2222_0000; mws[0][1] = 4'hC;
      repeat (3) @(posedge clk);
      #1;
      check_quiet(0, "rst_a");
      check_quiet(1, "rst_b");
      @(negedge clk);
      rst_n = 1'b1;

      // ---- contention: alternate grants, one IDLE cycle between transfers ----
      for (int i = 0; i < 4; i++) begin
         exp_who = 1 - last_m;
         data    = 32'h0C0C_0000 + 32'(i);
         run_txn(0, 1, data, (i == 3), 50, done, who, idle_n, k, rd, sv_r, er_r, er_any, ga, gwd, gws);
         check($sformatf("cont%0d_done", i), 32'(done), 32'd1);
         check($sformatf("cont%0d_who", i), 32'(who), 32'(exp_who));
         check($sformatf("cont%0d_idle", i), 32'(idle_n), 32'd1);
         check($sformatf("cont%0d_rdata", i), rd, data);
         check($sformatf("cont%0d_addr", i), ga, ma[0][exp_who]);
         check($sformatf("cont%0d_wstrb", i), 32'(gws), 32'(mws[0][exp_who]));
         check($sformatf("cont%0d_err", i), 32'(er_any), 32'd0);
         last_m = exp_who;
      end

      // ---- single m0 read, slave ready in GRANT cycle 2 ----
      mv[0][0] = 1'b1; ma[0][0] = 32'h1000_1000; mws[0][0] = 4'h0;
      run_txn(0, 2, 32'h55, 1, 50, done, who, idle_n, k, rd, sv_r, er_r, er_any, ga, gwd, gws);
      check("single_done", 32'(done), 32'd1);
      check("single_who", 32'(who), 32'd0);
      check("single_cycles", 32'(idle_n + k), 32'd3);
      check("single_rdata", rd, 32'h55);
      check("single_addr", ga, 32'h1000_1000);
      check("single_err", 32'(er_any), 32'd0);
      last_m = 0;

      // ---- timeout: m1, slave never ready ----
      mv[0][1] = 1'b1; ma[0][1] = 32'h1000_FF00;
      run_txn(0, 0, 32'h0, 1, 50, done, who, idle_n, k, rd, sv_r, er_r, er_any, ga, gwd, gws);
      check("to_done", 32'(done), 32'd1);
      check("to_who", 32'(who), 32'd1);
      check("to_cycle", 32'(k), 32'(TO_A));
      check("to_rdata", rd, ERR_WORD);
      check("to_s_valid", 32'(sv_r), 32'd0);
      check("to_err", 32'(er_r), 32'd1);
      check("to_err_addr", o_eaddr[0], 32'h1000_FF00);
      check("to_err_pulse", 32'(o_err[0]), 32'd0);
      last_m    = 1;
      exp_eaddr = 32'h1000_FF00;

      // ---- race: slave ready exactly in the timeout cycle ----
      mv[0][0] = 1'b1; ma[0][0] = 32'h2000_0040;
      run_txn(0, TO_A, 32'h1234, 1, 50, done, who, idle_n, k, rd, sv_r, er_r, er_any, ga, gwd, gws);
      check("race_done", 32'(done), 32'd1);
      check("race_who", 32'(who), 32'd0);
      check("race_cycle", 32'(k), 32'(TO_A));
      check("race_rdata", rd, 32'h1234);
      check("race_s_valid", 32'(sv_r), 32'd1);
      check("race_err", 32'(er_any), 32'd0);
      check("race_err_addr", o_eaddr[0], exp_eaddr);
      last_m = 0;

      // ---- randomized requests against the transaction model ----
      for (int r = 0; r < 20; r++) begin
         mode = int'($urandom_range(0, 2));
         lat  = int'($urandom_range(1, 11));
         data = $urandom;
         for (int m = 0; m < 2; m++) begin
            ma[0][m]  = $urandom;
            mwd[0][m] = $urandom;
            mws[0][m] = 4'($urandom);
         end
         mv[0][0] = (mode != 1);
         mv[0][1] = (mode != 0);
         exp_who  = (mode == 2) ? 1 - last_m : mode;
         exp_to   = (lat > TO_A);
         run_txn(0, lat, data, 1, 50, done, who, idle_n, k, rd, sv_r, er_r, er_any, ga, gwd, gws);
         check($sformatf("rnd%0d_done", r), 32'(done), 32'd1);
         check($sformatf("rnd%0d_who", r), 32'(who), 32'(exp_who));
         check($sformatf("rnd%0d_idle", r), 32'(idle_n), 32'd1);
         check($sformatf("rnd%0d_cycle", r), 32'(k), exp_to ? 32'(TO_A) : 32'(lat));
         check($sformatf("rnd%0d_rdata", r), rd, exp_to ? ERR_WORD : data);
         check($sformatf("rnd%0d_err", r), 32'(er_any), 32'(exp_to));
         check($sformatf("rnd%0d_addr", r), ga, ma[0][exp_who]);
         check($sformatf("rnd%0d_wdata", r), gwd, mwd[0][exp_who]);
         check($sformatf("rnd%0d_wstrb", r), 32'(gws), 32'(mws[0][exp_who]));
         if (exp_to) exp_eaddr = ma[0][exp_who];
         check($sformatf("rnd%0d_err_addr", r), o_eaddr[0], exp_eaddr);
         last_m = exp_who;
      end

      // ---- reset in the middle of a grant ----
      mv[0][0] = 1'b1; ma[0][0] = 32'h3000_0000;
      run_txn(0, 1, 32'h77, 1, 50, done, who, idle_n, k, rd, sv_r, er_r, er_any, ga, gwd, gws);
      check("pre_rst_who", 32'(who), 32'd0);
      mv[0][1] = 1'b1; ma[0][1] = 32'h3000_0100;
      @(posedge clk);
      #2;
      check("mid_s_valid_before", 32'(o_sv[0]), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_quiet(0, "mid_rst");
      mv[0][0] = 1'b1;
      #2;
      rst_n  = 1'b1;
      last_m = 1;
      exp_who = 1 - last_m;
      run_txn(0, 1, 32'hABCD, 1, 50, done, who, idle_n, k, rd, sv_r, er_r, er_any, ga, gwd, gws);
      check("post_rst_done", 32'(done), 32'd1);
      check("post_rst_who", 32'(who), 32'(exp_who));
      check("post_rst_rdata", rd, 32'hABCD);

      // ---- timeout disabled: 5000-cycle stall completes normally ----
      mv[1][0] = 1'b1; ma[1][0] = 32'h4000_0004; mwd[1][0] = 32'h0BAD_F00D; mws[1][0] = 4'hF;
      run_txn(1, 5000, 32'hCAFE_0001, 1, 6000, done, who, idle_n, k, rd, sv_r, er_r, er_any, ga, gwd, gws);
      check("notimeout_done", 32'(done), 32'd1);
      check("notimeout_who", 32'(who), 32'd0);
      check("notimeout_cycle", 32'(k), 32'd5000);
      check("notimeout_rdata", rd, 32'hCAFE_0001);
      check("notimeout_err", 32'(er_any), 32'd0);
      check("notimeout_wdata", gwd, 32'h0BAD_F00D);
      check("notimeout_err_addr", o_eaddr[1], 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
